// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
// Holds the loader state encodings, the default instruction memory depth,
// and small helper functions used by the FSM.
package imem_loader_pkg;

  // Default instruction memory depth in 32-bit words.
  localparam int unsigned INST_MEM_SIZE = 1024;

  // Loader FSM state encodings.
  localparam logic [2:0] LD_IDLE  = 3'd0;
  localparam logic [2:0] LD_HDR   = 3'd1;
  localparam logic [2:0] LD_DATA  = 3'd2;
  localparam logic [2:0] LD_WRITE = 3'd3;
  localparam logic [2:0] LD_CSUM  = 3'd4;
  localparam logic [2:0] LD_DONE  = 3'd5;
  localparam logic [2:0] LD_ERROR = 3'd6;

  // Byte address of the word at position index, relative to base.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] index);
    return base + {14'd0, index, 2'b00};
  endfunction

  // States in which the loader accepts stream bytes.
  function automatic logic is_rx_state(input logic [2:0] st);
    return (st == LD_HDR) || (st == LD_DATA) || (st == LD_CSUM);
  endfunction

  // States in which the core must be held. ERROR keeps the hold so a
  // partially loaded image can never execute.
  function automatic logic is_hold_state(input logic [2:0] st);
    return (st == LD_HDR) || (st == LD_DATA) || (st == LD_WRITE) ||
           (st == LD_CSUM) || (st == LD_ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Assembles big-endian 32-bit words from an accepted byte stream.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   clear         - drop any partial word and restart at byte 0
//   byte_in       - incoming byte
//   byte_valid    - byte_in is transferred this cycle
//   word          - assembled word (meaningful when word_valid)
//   word_valid    - the 4th byte of a word is transferred this cycle
module byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt_r;
  // Only the first three bytes need storage; the fourth completes the
  // word combinationally so the FSM can act on the same cycle.
  logic [23:0] shift_r;

  assign word       = {shift_r, byte_in};
  assign word_valid = byte_valid && (byte_cnt_r == 2'd3);

  // Byte counter and MSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt_r <= 2'd0;
      shift_r    <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      shift_r    <= {shift_r[15:0], byte_in};
    end else begin
      byte_cnt_r <= byte_cnt_r;
      shift_r    <= shift_r;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a program as a byte stream
// (header word count N, N data words, XOR checksum; all big-endian) and
// writes it word-by-word into instruction memory, holding the CPU while
// loading and releasing it only after a good checksum.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   start          - pulse to begin a session (IDLE/DONE/ERROR only)
//   rx_data/valid  - byte stream input; rx_ready grants the transfer
//   wr_en/addr/data- instruction memory write port, one strobe per word
//   cpu_hold       - stall request to the core
//   load_done      - level, load finished with matching checksum
//   load_error     - level, load aborted (oversize header or bad checksum)
//   words_written  - words written in the current session
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = INST_MEM_SIZE,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_written
);

  logic [2:0]  state_r;
  logic [2:0]  next_state_s;
  logic        rx_ready_r;
  logic        wr_en_r;
  logic [31:0] wr_addr_r;
  logic [31:0] wr_data_r;
  logic        cpu_hold_r;
  logic        load_done_r;
  logic        load_error_r;
  logic [15:0] words_written_r;
  logic [31:0] hdr_n_r;
  logic [31:0] csum_r;

  logic        xfer_s;
  logic        session_start_s;
  logic [31:0] word_s;
  logic        word_valid_s;
  logic [15:0] ww_next_s;
  logic        last_word_s;

  assign xfer_s          = rx_valid && rx_ready_r;
  assign session_start_s = start && ((state_r == LD_IDLE) ||
                                     (state_r == LD_DONE) ||
                                     (state_r == LD_ERROR));
  assign ww_next_s       = words_written_r + 16'd1;
  assign last_word_s     = ({16'd0, ww_next_s} == hdr_n_r);

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (session_start_s),
    .byte_in    (rx_data),
    .byte_valid (xfer_s),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  // Next-state logic for the load session FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) next_state_s = LD_HDR;
        else       next_state_s = state_r;
      end
      LD_HDR: begin
        if (word_valid_s) begin
          if (word_s > MEM_WORDS)   next_state_s = LD_ERROR;
          else if (word_s == 32'd0) next_state_s = LD_CSUM;
          else                      next_state_s = LD_DATA;
        end else begin
          next_state_s = state_r;
        end
      end
      LD_DATA: begin
        if (word_valid_s) next_state_s = LD_WRITE;
        else              next_state_s = state_r;
      end
      LD_WRITE: begin
        if (last_word_s) next_state_s = LD_CSUM;
        else             next_state_s = LD_DATA;
      end
      LD_CSUM: begin
        if (word_valid_s) begin
          if (word_s == csum_r) next_state_s = LD_DONE;
          else                  next_state_s = LD_ERROR;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = LD_IDLE;
    endcase
  end

  // State, registered outputs (decoded from next state), and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= LD_IDLE;
      rx_ready_r      <= 1'b0;
      wr_en_r         <= 1'b0;
      wr_addr_r       <= 32'd0;
      wr_data_r       <= 32'd0;
      cpu_hold_r      <= 1'b0;
      load_done_r     <= 1'b0;
      load_error_r    <= 1'b0;
      words_written_r <= 16'd0;
      hdr_n_r         <= 32'd0;
      csum_r          <= 32'd0;
    end else begin
      state_r      <= next_state_s;
      rx_ready_r   <= is_rx_state(next_state_s);
      wr_en_r      <= (next_state_s == LD_WRITE);
      cpu_hold_r   <= is_hold_state(next_state_s);
      load_done_r  <= (next_state_s == LD_DONE);
      load_error_r <= (next_state_s == LD_ERROR);

      if (session_start_s) begin
        words_written_r <= 16'd0;
        csum_r          <= 32'd0;
        hdr_n_r         <= 32'd0;
      end else if (state_r == LD_HDR && word_valid_s) begin
        hdr_n_r <= word_s;
      end else if (state_r == LD_DATA && word_valid_s) begin
        // Present the word during the WRITE cycle; index = words so far.
        wr_data_r <= word_s;
        wr_addr_r <= word_addr(BASE_ADDR, words_written_r);
      end else if (state_r == LD_WRITE) begin
        csum_r          <= csum_r ^ wr_data_r;
        words_written_r <= ww_next_s;
      end else begin
        words_written_r <= words_written_r;
      end
    end
  end

  assign rx_ready      = rx_ready_r;
  assign wr_en         = wr_en_r;
  assign wr_addr       = wr_addr_r;
  assign wr_data       = wr_data_r;
  assign cpu_hold      = cpu_hold_r;
  assign load_done     = load_done_r;
  assign load_error    = load_error_r;
  assign words_written = words_written_r;

endmodule
